muldiv_sequencer: RTL and testbench

//  Multi-cycle multiply/divide unit with architectural HI/LO registers, alongside the EX-stage ALU.

---
 rtl/muldiv_sequencer.sv | 165 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring shift-subtract divide, one bit per cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             mf_req,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             stall
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic             dz;

    // Operand conditioning at accept time
    logic             b_zero;
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    // Iteration datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // Sign-corrected result
    logic [W2-1:0]    prod;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    assign stall = busy & (start | mf_req | hi_we | lo_we);

    always_comb begin
        b_zero    = (src_b == '0);
        // A zero divisor runs unsigned so the remainder path returns the raw dividend
        sgn       = ~op[0] & ~(op[1] & b_zero);
        a_neg     = sgn & src_a[WIDTH-1];
        b_neg     = sgn & src_b[WIDTH-1];
        abs_a     = a_neg ? (~src_a + WIDTH'(1)) : src_a;
        abs_b     = b_neg ? (~src_b + WIDTH'(1)) : src_b;

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        // Partial remainder is always below 2*divisor, so bit WIDTH of the difference is the borrow
        div_diff  = div_shift - {1'b0, opnd};

        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_lo ? (~prod + W2'(1)) : prod;
        if (is_div) begin
            fix_hi = neg_hi ? (~acc_hi + WIDTH'(1)) : acc_hi;
            fix_lo = neg_lo ? (~acc_lo + WIDTH'(1)) : acc_lo;
        end else begin
            fix_hi = prod_fix[W2-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wr_data;
                    if (lo_we) lo <= wr_data;
                    if (start && !flush) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= CW'(WIDTH - 1);
                        acc_hi <= '0;
                        is_div <= op[1];
                        dz     <= op[1] & b_zero;
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        // Multiply walks the multiplier in acc_lo; divide shifts the dividend out of it
                        acc_lo <= op[1] ? abs_a : abs_b;
                        opnd   <= op[1] ? abs_b : abs_a;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            if (div_diff[WIDTH]) begin
                                acc_hi <= div_shift[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                            end else begin
                                acc_hi <= div_diff[WIDTH-1:0];
                                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                            end
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                        end
                        if (count == '0) state <= FIXUP;
                        else             count <= count - CW'(1);
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi       <= fix_hi;
                        lo       <= fix_lo;
                        done     <= 1'b1;
                        div_zero <= dz;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: table of directed mult/div vectors
// plus hand-written sequences for stall, flush, reset and HI/LO write corner cases.
module tb_muldiv_sequencer;

    localparam int unsigned W   = 32;
    localparam int          LAT = W + 2;
    localparam logic [1:0]  MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         flush;
    logic         mf_req;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wr_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         stall;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .mf_req(mf_req), .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents an op for one cycle; returns at the negedge after the accepting edge
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; src_a = $urandom; src_b = $urandom;
    endtask

    // Counts accepting-edge-relative cycles until done, bounded
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        int hold_bad;
        logic [W-1:0] old_hi, old_lo;

        vecs[0]  = '{MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{DIVU,  32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[5]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[6]  = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[7]  = '{MULT,  32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0};
        vecs[8]  = '{DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 1'b0};
        vecs[9]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        flush = 1'b0; mf_req = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset hi", 64'(hi), 64'h0);
        chk("reset lo", 64'(lo), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        chk("reset done", 64'(done), 64'h0);
        chk("reset div_zero", 64'(div_zero), 64'h0);
        chk("reset stall", 64'(stall), 64'h0);

        // mthi / mtlo while idle
        hi_we = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h5678;
        chk("mthi idle", 64'(hi), 64'h1234);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo idle", 64'(lo), 64'h5678);

        // Directed operation table
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d busy", i), 64'(busy), 64'h1);
            wait_done(1, n);
            chk($sformatf("v%0d latency", i), 64'(n), 64'(LAT));
            chk($sformatf("v%0d {hi,lo}", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            chk($sformatf("v%0d div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
            chk($sformatf("v%0d busy at done", i), 64'(busy), 64'h0);
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i), 64'({done, div_zero}), 64'h0);
        end

        // mf_req and a second start while busy: stall held, hi/lo frozen, op taken after busy falls
        old_hi = hi; old_lo = lo;
        issue(MULT, 32'd3, 32'd4);
        n = 1; cnt = 0; hold_bad = 0;
        while (!done && n < 60) begin
            if (n == 5) begin
                mf_req = 1'b1; start = 1'b1; op = MULTU; src_a = 32'd6; src_b = 32'd7;
            end
            #1;
            if (stall) cnt++;
            if (hi !== old_hi || lo !== old_lo) hold_bad++;
            @(negedge clk);
            n++;
        end
        chk("stall first latency", 64'(n), 64'(LAT));
        chk("stall cycle count", 64'(cnt), 64'(LAT - 5));
        chk("hi/lo held while busy", 64'(hold_bad), 64'h0);
        chk("stall first result", {hi, lo}, {32'd0, 32'd12});
        chk("stall low at done", 64'(stall), 64'h0);
        @(negedge clk);
        start = 1'b0; mf_req = 1'b0;
        chk("second op accepted", 64'(busy), 64'h1);
        wait_done(1, n);
        chk("second op latency", 64'(n), 64'(LAT));
        chk("second op result", {hi, lo}, {32'd0, 32'd42});

        // flush mid-divide
        old_hi = hi; old_lo = lo;
        issue(DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'h0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("flush no done", 64'(cnt), 64'h0);
        chk("flush hi/lo kept", {hi, lo}, {old_hi, old_lo});

        // flush with start in idle
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = MULTU; src_a = 32'd2; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush+start ignored", 64'(busy), 64'h0);

        // start with mthi in the same idle cycle: write now, result overwrites later
        @(negedge clk);
        start = 1'b1; op = DIVU; src_a = 32'd50; src_b = 32'd7; hi_we = 1'b1; wr_data = 32'hABCD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("mthi with start", 64'(hi), 64'hABCD);
        wait_done(1, n);
        chk("divu 50/7 latency", 64'(n), 64'(LAT));
        chk("divu 50/7 result", {hi, lo}, {32'd1, 32'd7});

        // mtlo while busy is ignored and stalls
        old_lo = lo;
        issue(MULT, 32'd7, 32'hFFFFFFFB);
        @(negedge clk);
        lo_we = 1'b1; wr_data = 32'hDEAD;
        #1;
        chk("mtlo busy stall", 64'(stall), 64'h1);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo busy ignored", 64'(lo), 64'(old_lo));
        wait_done(3, n);
        chk("mult after mtlo latency", 64'(n), 64'(LAT));
        chk("mult after mtlo result", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFDD});

        // reset mid-operation
        issue(MULTU, 32'hFFFFFFFF, 32'd2);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midop reset hi/lo", {hi, lo}, 64'h0);
        chk("midop reset busy", 64'(busy), 64'h0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("midop reset no done", 64'(cnt), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
